// File: rtl/team_08_render_pkg.sv
// Shared types and sprite geometry for the dino game object renderer.
package team_08_render_pkg;

  typedef enum logic [1:0] {
    GameIdle = 2'd0,
    GameRun  = 2'd1,
    GameOver = 2'd2,
    GameWin  = 2'd3
  } game_st_t;

  typedef enum logic [0:0] {
    BufEmpty   = 1'b0,
    BufPending = 1'b1
  } buf_st_t;

  typedef struct packed {
    logic [7:0] dino_y;
    logic [8:0] cactus_x;
    game_st_t   st;
  } obj_set_t;

  localparam int unsigned DINO_W     = 20;
  localparam int unsigned DINO_H     = 22;
  localparam int unsigned DINO_LEG_H = 4;
  localparam int unsigned CACTUS_W   = 10;
  localparam int unsigned CACTUS_H   = 20;
  localparam int unsigned CLOUD_W    = 30;
  localparam int unsigned CLOUD_H    = 10;
  localparam int unsigned CLOUD_Y    = 30;

  // Banner box, inclusive bounds
  localparam int unsigned BANNER_X0 = 100;
  localparam int unsigned BANNER_X1 = 219;
  localparam int unsigned BANNER_Y0 = 60;
  localparam int unsigned BANNER_Y1 = 99;

endpackage

// File: rtl/team_08_rect_hit.sv
// Combinational box test in 10-bit unsigned space: hit when (px,py) lies in [o, o+size).
module team_08_rect_hit (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] ox,
  input  logic [9:0] oy,
  input  logic [9:0] w,
  input  logic [9:0] h,
  output logic       hit
);

  assign hit = (px >= ox) && (px < ox + w) && (py >= oy) && (py < oy + h);

endmodule

// File: rtl/team_08_object_renderer.sv
// Per-pixel object decoder for the dino game display path.
// Cloud sprite and its position buffer exist only when TEAM_08_CLOUD_EN is defined.
module team_08_object_renderer
  import team_08_render_pkg::*;
#(
  parameter int unsigned SCR_W      = 320,
  parameter int unsigned SCR_H      = 240,
  parameter int unsigned FLOOR_Y    = 200,
  parameter int unsigned DINO_X     = 40,
  parameter int unsigned LEG_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_stb,
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic       pos_valid,
  output logic       pos_ready,
  input  logic [7:0] dino_y,
  input  logic [8:0] cactus_x,
  input  logic [8:0] cloud_x,
  input  logic [1:0] game_st,
  output logic       r_floor,
  output logic       r_cactus,
  output logic       r_dino,
  output logic       r_cloud,
  output logic       r_idle,
  output logic       r_over,
  output logic       r_win,
  output logic       leg_phase
);

  localparam int unsigned CntW = (LEG_FRAMES > 1) ? $clog2(LEG_FRAMES) : 1;
  localparam obj_set_t ActReset = '{
    dino_y:   8'(FLOOR_Y - DINO_H),
    cactus_x: 9'(SCR_W),
    st:       GameIdle
  };

  buf_st_t         buf_q, buf_d;
  obj_set_t        pend_q, act_q, act_eff;
  logic            frame_start, load_pend, apply_pend;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            leg_q, leg_d;
  logic [9:0]      px, py;
  logic            on_screen, cactus_box, dino_box, banner_box, leg_row, left_half, dino_hit;

  assign frame_start = pix_stb && (x == 9'd0) && (y == 8'd0);
  assign pos_ready   = (buf_q == BufEmpty);
  assign leg_phase   = leg_q;

  always_comb begin
    buf_d      = buf_q;
    load_pend  = 1'b0;
    apply_pend = 1'b0;
    case (buf_q)
      BufEmpty: begin
        if (pos_valid) begin
          load_pend = 1'b1;
          buf_d     = BufPending;
        end
      end
      BufPending: begin
        if (frame_start) begin
          apply_pend = 1'b1;
          buf_d      = BufEmpty;
        end
      end
      default: buf_d = BufEmpty;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    leg_d = leg_q;
    if (frame_start) begin
      if (cnt_q == CntW'(LEG_FRAMES - 1)) begin
        cnt_d = '0;
        leg_d = ~leg_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q  <= BufEmpty;
      pend_q <= ActReset;
      act_q  <= ActReset;
      cnt_q  <= '0;
      leg_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      leg_q <= leg_d;
      if (load_pend) begin
        pend_q <= '{dino_y: dino_y, cactus_x: cactus_x, st: game_st_t'(game_st)};
      end
      if (apply_pend) begin
        act_q <= pend_q;
      end
    end
  end

  // The frame-start pixel already sees the set being applied and the new leg phase
  assign act_eff = apply_pend ? pend_q : act_q;

  assign px        = {1'b0, x};
  assign py        = {2'b00, y};
  assign on_screen = (px < 10'(SCR_W)) && (py < 10'(SCR_H));

  team_08_rect_hit u_cactus (
    .px  (px),
    .py  (py),
    .ox  ({1'b0, act_eff.cactus_x}),
    .oy  (10'(FLOOR_Y - CACTUS_H)),
    .w   (10'(CACTUS_W)),
    .h   (10'(CACTUS_H)),
    .hit (cactus_box)
  );

  team_08_rect_hit u_dino (
    .px  (px),
    .py  (py),
    .ox  (10'(DINO_X)),
    .oy  ({2'b00, act_eff.dino_y}),
    .w   (10'(DINO_W)),
    .h   (10'(DINO_H)),
    .hit (dino_box)
  );

  team_08_rect_hit u_banner (
    .px  (px),
    .py  (py),
    .ox  (10'(BANNER_X0)),
    .oy  (10'(BANNER_Y0)),
    .w   (10'(BANNER_X1 - BANNER_X0 + 1)),
    .h   (10'(BANNER_Y1 - BANNER_Y0 + 1)),
    .hit (banner_box)
  );

  // Leg rows draw the left half on phase 0 and the right half on phase 1
  assign leg_row   = py >= ({2'b00, act_eff.dino_y} + 10'(DINO_H - DINO_LEG_H));
  assign left_half = px < 10'(DINO_X + DINO_W / 2);
  assign dino_hit  = dino_box && (!leg_row || (left_half ^ leg_d));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_floor  <= 1'b0;
      r_cactus <= 1'b0;
      r_dino   <= 1'b0;
      r_idle   <= 1'b0;
      r_over   <= 1'b0;
      r_win    <= 1'b0;
    end else if (pix_stb) begin
      r_floor  <= on_screen && (py >= 10'(FLOOR_Y));
      r_cactus <= on_screen && cactus_box;
      r_dino   <= on_screen && dino_hit;
      r_idle   <= on_screen && banner_box && (act_eff.st == GameIdle);
      r_over   <= on_screen && banner_box && (act_eff.st == GameOver);
      r_win    <= on_screen && banner_box && (act_eff.st == GameWin);
    end
  end

`ifdef TEAM_08_CLOUD_EN
  logic [8:0] cloud_pend_q, cloud_act_q, cloud_eff;
  logic       cloud_box;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cloud_pend_q <= 9'(SCR_W);
      cloud_act_q  <= 9'(SCR_W);
    end else begin
      if (load_pend)  cloud_pend_q <= cloud_x;
      if (apply_pend) cloud_act_q  <= cloud_pend_q;
    end
  end

  assign cloud_eff = apply_pend ? cloud_pend_q : cloud_act_q;

  team_08_rect_hit u_cloud (
    .px  (px),
    .py  (py),
    .ox  ({1'b0, cloud_eff}),
    .oy  (10'(CLOUD_Y)),
    .w   (10'(CLOUD_W)),
    .h   (10'(CLOUD_H)),
    .hit (cloud_box)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cloud <= 1'b0;
    end else if (pix_stb) begin
      r_cloud <= on_screen && cloud_box;
    end
  end
`else
  logic unused_cloud;
  assign unused_cloud = ^cloud_x;
  assign r_cloud      = 1'b0;
`endif

endmodule
